// File: rtl/hh_ctrl_pkg.sv
// Shared definitions for the HitchHike backscatter sequencing controller.
// Holds the controller state encoding, the pulse-width command codes
// (in command units) and the width of the unit counter.
package hh_ctrl_pkg;

    localparam int UNIT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MEASURE = 3'd1,
        ST_DECODE  = 3'd2,
        ST_GUARD   = 3'd3,
        ST_TX      = 3'd4
    } state_t;

    localparam logic [UNIT_W-1:0] CMD_GLITCH = 4'd0;
    localparam logic [UNIT_W-1:0] CMD_START  = 4'd4;
    localparam logic [UNIT_W-1:0] CMD_RATE0  = 4'd5;
    localparam logic [UNIT_W-1:0] CMD_RATE1  = 4'd6;
    localparam logic [UNIT_W-1:0] CMD_RATE2  = 4'd7;
    localparam logic [UNIT_W-1:0] CMD_RATE3  = 4'd8;

    // Rate commands are consecutive, so the rate code is the offset from RATE0.
    function automatic logic [1:0] rate_code(input logic [UNIT_W-1:0] u);
        return 2'(u - CMD_RATE0);
    endfunction

endpackage

// File: rtl/hh_pulse_meter.sv
// Pulse-width meter for the envelope-detector trigger.
// Synchronizes trigger_signal (2 flops), detects its rising edge and measures
// the high time in command units, rounding to the nearest unit (saturating).
// Ports:
//   clock, reset       : system clock, async active-high reset
//   en                 : measurement enable (low while the controller is busy)
//   trigger_signal     : raw asynchronous envelope input
//   meas_start         : 1-cycle pulse, a measurement begins (next cycle counts)
//   meas_valid         : high on the first cycle the synchronized trigger is low
//   units              : rounded pulse width, valid with meas_valid
module hh_pulse_meter
    import hh_ctrl_pkg::*;
#(
    parameter int UNIT_CYCLES = 20
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic              trigger_signal,
    output logic              meas_start,
    output logic              meas_valid,
    output logic [UNIT_W-1:0] units
);

    localparam int SUB_W = $clog2(UNIT_CYCLES);
    localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(UNIT_CYCLES - 1);
    localparam logic [SUB_W-1:0]  SUB_HALF = SUB_W'(UNIT_CYCLES / 2);
    localparam logic [UNIT_W-1:0] UNIT_MAX = '1;

    logic              sync1;
    logic              trig_s;
    logic              trig_d;
    logic              measuring;
    logic              rise;
    logic [SUB_W-1:0]  sub_cnt;
    logic [UNIT_W-1:0] unit_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1  <= 1'b0;
            trig_s <= 1'b0;
            trig_d <= 1'b0;
        end else begin
            sync1  <= trigger_signal;
            trig_s <= sync1;
            trig_d <= trig_s;
        end
    end

    // The edge detector keeps running while disabled, so a pulse that began
    // during a busy period is only measured from its next rising edge.
    assign rise       = trig_s & ~trig_d;
    assign meas_start = en & ~measuring & rise;
    assign meas_valid = en & measuring & ~trig_s;

    always_comb begin
        units = unit_cnt;
        if ((sub_cnt >= SUB_HALF) && (unit_cnt != UNIT_MAX)) begin
            units = unit_cnt + UNIT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            measuring <= 1'b0;
            sub_cnt   <= '0;
            unit_cnt  <= '0;
        end else if (!en) begin
            measuring <= 1'b0;
        end else if (meas_start) begin
            measuring <= 1'b1;
            sub_cnt   <= '0;
            unit_cnt  <= '0;
        end else if (measuring) begin
            if (!trig_s) begin
                measuring <= 1'b0;
            end else if (sub_cnt == SUB_LAST) begin
                sub_cnt <= '0;
                if (unit_cnt != UNIT_MAX) begin
                    unit_cnt <= unit_cnt + UNIT_W'(1);
                end
            end else begin
                sub_cnt <= sub_cnt + SUB_W'(1);
            end
        end
    end

endmodule

// File: rtl/hh_backscatter_ctrl.sv
// HitchHike tag sequencing controller.
// Decodes pulse-width commands on trigger_signal, holds the data-rate setting,
// buffers one payload word and, on START, drives the codeword-translation
// modulator bit by bit (MSB first) after a guard interval.
// Ports:
//   clock, reset        : system clock, async active-high reset
//   trigger_signal      : asynchronous envelope input, pulse-width coded
//   payload_data/valid  : payload offer; payload_ready high when buffer empty
//   mod_enable, mod_bit : modulator enable and current bit (1 = phase flip)
//   bit_strobe          : 1-cycle pulse on the first cycle of each bit
//   rate_sel            : current data-rate code
//   busy                : high during GUARD and TX
//   done, err           : 1-cycle completion / error pulses
module hh_backscatter_ctrl
    import hh_ctrl_pkg::*;
#(
    parameter int UNIT_CYCLES     = 20,
    parameter int PAYLOAD_BITS    = 32,
    parameter int BASE_BIT_CYCLES = 20,
    parameter int GUARD_CYCLES    = 40
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    trigger_signal,
    input  logic [PAYLOAD_BITS-1:0] payload_data,
    input  logic                    payload_valid,
    output logic                    payload_ready,
    output logic                    mod_enable,
    output logic                    mod_bit,
    output logic                    bit_strobe,
    output logic [1:0]              rate_sel,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int TMR_W  = $clog2(BASE_BIT_CYCLES * 8 + 1);
    localparam int BIDX_W = $clog2(PAYLOAD_BITS + 1);
    localparam int GCNT_W = $clog2(GUARD_CYCLES + 1);

    state_t                  state;
    state_t                  state_n;
    logic                    meas_start;
    logic                    meas_valid;
    logic [UNIT_W-1:0]       units;
    logic [UNIT_W-1:0]       cmd_units;

    logic                    buf_valid;
    logic [PAYLOAD_BITS-1:0] buf_data;
    logic [PAYLOAD_BITS-1:0] shreg;
    logic [1:0]              tx_rate;
    logic [GCNT_W-1:0]       gcnt;
    logic [TMR_W-1:0]        tmr;
    logic [BIDX_W-1:0]       bidx;
    logic [TMR_W-1:0]        bit_period;
    logic                    tmr_last;
    logic                    bit_last;

    logic                    start_tx;
    logic                    err_n;
    logic                    done_n;
    logic                    rate_wr;
    logic [1:0]              rate_n;

    hh_pulse_meter #(
        .UNIT_CYCLES(UNIT_CYCLES)
    ) u_meter (
        .clock         (clock),
        .reset         (reset),
        .en            (!busy),
        .trigger_signal(trigger_signal),
        .meas_start    (meas_start),
        .meas_valid    (meas_valid),
        .units         (units)
    );

    assign bit_period = TMR_W'(BASE_BIT_CYCLES) << tx_rate;
    assign tmr_last   = (tmr == bit_period - TMR_W'(1));
    assign bit_last   = (bidx == BIDX_W'(PAYLOAD_BITS - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        start_tx = 1'b0;
        err_n    = 1'b0;
        done_n   = 1'b0;
        rate_wr  = 1'b0;
        rate_n   = rate_sel;
        case (state)
            ST_IDLE: begin
                if (meas_start) begin
                    state_n = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (meas_valid) begin
                    state_n = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_n = ST_IDLE;
                case (cmd_units)
                    CMD_GLITCH: ;
                    CMD_START: begin
                        // Only a word already held counts; a word arriving this
                        // same cycle just loads.
                        if (buf_valid) begin
                            start_tx = 1'b1;
                            state_n  = ST_GUARD;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                    CMD_RATE0, CMD_RATE1, CMD_RATE2, CMD_RATE3: begin
                        rate_wr = 1'b1;
                        rate_n  = rate_code(cmd_units);
                    end
                    default: err_n = 1'b1;
                endcase
            end
            ST_GUARD: begin
                if (gcnt == GCNT_W'(GUARD_CYCLES - 1)) begin
                    state_n = ST_TX;
                end
            end
            ST_TX: begin
                if (tmr_last && bit_last) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmd_units <= '0;
            buf_valid <= 1'b0;
            buf_data  <= '0;
            shreg     <= '0;
            tx_rate   <= '0;
            gcnt      <= '0;
            tmr       <= '0;
            bidx      <= '0;
            rate_sel  <= '0;
            err       <= 1'b0;
            done      <= 1'b0;
        end else begin
            err  <= err_n;
            done <= done_n;

            if ((state == ST_MEASURE) && meas_valid) begin
                cmd_units <= units;
            end

            if (rate_wr) begin
                rate_sel <= rate_n;
            end

            // Load and consume are mutually exclusive: load needs an empty
            // buffer, START consumes a full one.
            if (payload_valid && !buf_valid) begin
                buf_valid <= 1'b1;
                buf_data  <= payload_data;
            end else if (start_tx) begin
                buf_valid <= 1'b0;
            end

            if (start_tx) begin
                shreg   <= buf_data;
                tx_rate <= rate_sel;
                gcnt    <= '0;
            end

            if (state == ST_GUARD) begin
                gcnt <= gcnt + GCNT_W'(1);
                tmr  <= '0;
                bidx <= '0;
            end

            if (state == ST_TX) begin
                if (tmr_last) begin
                    tmr   <= '0;
                    shreg <= shreg << 1;
                    bidx  <= bidx + BIDX_W'(1);
                end else begin
                    tmr <= tmr + TMR_W'(1);
                end
            end
        end
    end

    assign payload_ready = !buf_valid;
    assign mod_enable    = (state == ST_TX);
    assign mod_bit       = mod_enable & shreg[PAYLOAD_BITS-1];
    assign bit_strobe    = mod_enable & (tmr == '0);
    assign busy          = (state == ST_GUARD) || (state == ST_TX);

endmodule

// File: tb/tb_hh_backscatter_ctrl.sv
// Directed bench for hh_backscatter_ctrl at default parameters.
module tb_hh_backscatter_ctrl;

    logic        clock;
    logic        reset;
    logic        trigger_signal;
    logic [31:0] payload_data;
    logic        payload_valid;
    logic        payload_ready;
    logic        mod_enable;
    logic        mod_bit;
    logic        bit_strobe;
    logic [1:0]  rate_sel;
    logic        busy;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;

    // Per-run observations
    int          err_cnt, err_first, en_first, en_cnt, stb_cnt, done_cnt, done_tick, busy_cnt;
    bit          rdy_low, hit_rst;
    logic [63:0] bits;

    hh_backscatter_ctrl #(
        .UNIT_CYCLES    (20),
        .PAYLOAD_BITS   (32),
        .BASE_BIT_CYCLES(20),
        .GUARD_CYCLES   (40)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .trigger_signal(trigger_signal),
        .payload_data  (payload_data),
        .payload_valid (payload_valid),
        .payload_ready (payload_ready),
        .mod_enable    (mod_enable),
        .mod_bit       (mod_bit),
        .bit_strobe    (bit_strobe),
        .rate_sel      (rate_sel),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [31:0] w);
        payload_data  = w;
        payload_valid = 1'b1;
        tick();
        payload_valid = 1'b0;
    endtask

    // Drives a trigger pulse of n cycles, then observes win cycles.
    // inj=1: 5-unit trigger pulse plus load of w_inj during the window.
    // inj=2: load of w_inj at cycle 100.  rst_bit>=0: assert reset at that bit.
    task automatic run(input int n, input int win, input int inj,
                       input logic [31:0] w_inj, input int rst_bit);
        trigger_signal = 1'b1;
        repeat (n) tick();
        trigger_signal = 1'b0;
        err_cnt = 0; err_first = -1; en_first = -1; en_cnt = 0; stb_cnt = 0;
        done_cnt = 0; done_tick = -1; busy_cnt = 0; rdy_low = 1'b0; hit_rst = 1'b0;
        bits = '0;
        for (int k = 1; k <= win; k++) begin
            if (inj == 1) begin
                if (k == 200) trigger_signal = 1'b1;
                if (k == 300) trigger_signal = 1'b0;
                if (k == 400) begin payload_data = w_inj; payload_valid = 1'b1; end
                if (k == 401) payload_valid = 1'b0;
            end else if (inj == 2) begin
                if (k == 100) begin payload_data = w_inj; payload_valid = 1'b1; end
                if (k == 101) payload_valid = 1'b0;
            end
            tick();
            if (err) begin err_cnt++; if (err_first < 0) err_first = k; end
            if (mod_enable) begin en_cnt++; if (en_first < 0) en_first = k; end
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; if (done_tick < 0) done_tick = k; end
            if (!payload_ready) rdy_low = 1'b1;
            if (bit_strobe) begin
                if (rst_bit >= 0 && stb_cnt == rst_bit) begin
                    reset = 1'b1;
                    #1;
                    check("async_mod_enable_drop", 64'(mod_enable), 64'd0);
                    check("async_busy_drop", 64'(busy), 64'd0);
                    hit_rst = 1'b1;
                    break;
                end
                bits = {bits[62:0], mod_bit};
                stb_cnt++;
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        trigger_signal = 1'b0;
        payload_data   = '0;
        payload_valid  = 1'b0;
        repeat (3) tick();
        check("rst_payload_ready", 64'(payload_ready), 64'd1);
        check("rst_rate_sel", 64'(rate_sel), 64'd0);
        check("rst_outputs", 64'({mod_enable, mod_bit, bit_strobe, busy, done, err}), 64'd0);
        reset = 1'b0;
        repeat (3) tick();

        // START with an empty buffer
        run(80, 12, 0, '0, -1);
        check("empty_start_err_cnt", 64'(err_cnt), 64'd1);
        check("empty_start_err_latency", 64'(err_first), 64'd4);
        check("empty_start_no_tx", 64'(en_cnt), 64'd0);

        load(32'hA5A5_0F0F);
        tick();
        check("ready_low_after_load", 64'(payload_ready), 64'd0);

        run(120, 12, 0, '0, -1);
        check("rate1_rate_sel", 64'(rate_sel), 64'd1);
        check("rate1_no_err", 64'(err_cnt), 64'd0);

        run(80, 1400, 0, '0, -1);
        check("tx1_no_err", 64'(err_cnt), 64'd0);
        check("tx1_enable_rise", 64'(en_first), 64'd44);
        check("tx1_enable_len", 64'(en_cnt), 64'd1280);
        check("tx1_strobes", 64'(stb_cnt), 64'd32);
        check("tx1_bits", bits, 64'h0000_0000_A5A5_0F0F);
        check("tx1_done_cnt", 64'(done_cnt), 64'd1);
        check("tx1_done_tick", 64'(done_tick), 64'd1324);
        check("tx1_busy_len", 64'(busy_cnt), 64'd1320);
        check("tx1_ready_after", 64'(payload_ready), 64'd1);

        // Rounding and command boundaries
        run(89, 12, 0, '0, -1);
        check("round89_is_start_err", 64'(err_cnt), 64'd1);
        check("round89_no_tx", 64'(en_cnt), 64'd0);
        run(91, 12, 0, '0, -1);
        check("round91_rate0", 64'(rate_sel), 64'd0);
        check("round91_no_err", 64'(err_cnt), 64'd0);
        run(160, 12, 0, '0, -1);
        check("rate3_rate_sel", 64'(rate_sel), 64'd3);
        run(9, 12, 0, '0, -1);
        check("glitch_no_err", 64'(err_cnt), 64'd0);
        check("glitch_rate_kept", 64'(rate_sel), 64'd3);
        run(240, 12, 0, '0, -1);
        check("unit12_err", 64'(err_cnt), 64'd1);
        check("unit12_rate_kept", 64'(rate_sel), 64'd3);
        run(400, 12, 0, '0, -1);
        check("saturated_err", 64'(err_cnt), 64'd1);

        // Commands and loads during TX
        run(120, 12, 0, '0, -1);
        check("rate1_again", 64'(rate_sel), 64'd1);
        load(32'h0123_4567);
        run(80, 1400, 1, 32'h8000_0001, -1);
        check("tx2_bits", bits, 64'h0000_0000_0123_4567);
        check("tx2_no_err", 64'(err_cnt), 64'd0);
        check("tx2_rate_kept", 64'(rate_sel), 64'd1);
        check("tx2_ready_dropped", 64'(rdy_low), 64'd1);
        check("tx2_buffer_full_after", 64'(payload_ready), 64'd0);
        run(80, 1400, 0, '0, -1);
        check("tx3_bits", bits, 64'h0000_0000_8000_0001);
        check("tx3_done_cnt", 64'(done_cnt), 64'd1);
        check("tx3_strobes", 64'(stb_cnt), 64'd32);

        // Reset mid-packet at bit 10, with a second word buffered
        load(32'hFFFF_FFFF);
        run(80, 1400, 2, 32'h1234_5678, 10);
        check("rst_hit_bit10", 64'(hit_rst), 64'd1);
        check("rst_bits_before", bits, 64'h0000_0000_0000_03FF);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_ready", 64'(payload_ready), 64'd1);
        check("post_rst_rate_sel", 64'(rate_sel), 64'd0);
        check("post_rst_mod_enable", 64'(mod_enable), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
